// File: rtl/redundancy_table_updater.sv
// Commits checker MT/ST results into table storage (OR-merge MT, overwrite ST) and bulk-clears it.
// Latency: done 2 cycles after accept (3 with dest_en); clear takes ENTRIES cycles. Optional red_count via REDUNDANCY_UPDATER_COUNT_EN.
module redundancy_table_updater #(
    parameter int STEP_RANGE    = 128,
    parameter int MAX_LIFM_RSIZ = 3,
    parameter int ITER_WIDTH    = 9
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        clr_start,
    input  logic                                        upd_valid,
    output logic                                        upd_ready,
    input  logic                                        dest_en,
    input  logic [ITER_WIDTH-1:0]                       src_idx,
    input  logic [ITER_WIDTH-1:0]                       dest_idx,
    input  logic [STEP_RANGE-1:0]                       n_src_mt,
    input  logic [STEP_RANGE-1:0]                       n_dest_mt,
    input  logic [1:0]                                  n_src_st,
    input  logic [1:0]                                  n_dest_st,
    output logic [MAX_LIFM_RSIZ*STEP_RANGE*STEP_RANGE-1:0] mt_buffer,
    output logic [MAX_LIFM_RSIZ*STEP_RANGE*2-1:0]       st_buffer,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        idx_err
`ifdef REDUNDANCY_UPDATER_COUNT_EN
    ,
    output logic [ITER_WIDTH:0]                         red_count
`endif
);
    localparam int ENTRIES = MAX_LIFM_RSIZ * STEP_RANGE;
    localparam logic [ITER_WIDTH:0]   ENTRIES_W = (ITER_WIDTH+1)'(ENTRIES);
    localparam logic [ITER_WIDTH-1:0] LAST_IDX  = ITER_WIDTH'(ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SRC_WR, DEST_WR, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ITER_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    dest_en_q, dest_en_d;
    logic [ITER_WIDTH-1:0]   src_q, src_d, dest_q, dest_d;
    logic [STEP_RANGE-1:0]   src_mt_q, src_mt_d, dest_mt_q, dest_mt_d;
    logic [1:0]              src_st_q, src_st_d, dest_st_q, dest_st_d;
    logic                    done_q, done_d;
    logic                    idx_err_q, idx_err_d;

    logic [STEP_RANGE-1:0]   mt_q [ENTRIES];
    logic [1:0]              st_q [ENTRIES];

    logic                    wr_en;
    logic [ITER_WIDTH-1:0]   wr_idx;
    logic [STEP_RANGE-1:0]   wr_mt;
    logic [1:0]              wr_st;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_en_d = dest_en_q;
        src_d     = src_q;
        dest_d    = dest_q;
        src_mt_d  = src_mt_q;
        dest_mt_d = dest_mt_q;
        src_st_d  = src_st_q;
        dest_st_d = dest_st_q;
        done_d    = 1'b0;
        idx_err_d = idx_err_q;
        wr_en     = 1'b0;
        wr_idx    = cnt_q;
        wr_mt     = '0;
        wr_st     = '0;
        upd_ready = (state_q == IDLE) && !clr_start;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    cnt_d     = '0;
                    idx_err_d = 1'b0;
                end else if (upd_valid) begin
                    state_d   = SRC_WR;
                    dest_en_d = dest_en;
                    src_d     = src_idx;
                    dest_d    = dest_idx;
                    src_mt_d  = n_src_mt;
                    dest_mt_d = n_dest_mt;
                    src_st_d  = n_src_st;
                    dest_st_d = n_dest_st;
                end
            end
            SRC_WR: begin
                wr_idx = src_q;
                wr_mt  = mt_q[src_q] | src_mt_q;
                wr_st  = src_st_q;
                // Out-of-range writes are dropped but the sequence still runs to completion.
                if ({1'b0, src_q} < ENTRIES_W) wr_en = 1'b1;
                else                           idx_err_d = 1'b1;
                if (dest_en_q) begin
                    state_d = DEST_WR;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            DEST_WR: begin
                // Reads storage after the SRC_WR commit, so src==dest merges both vectors.
                wr_idx = dest_q;
                wr_mt  = mt_q[dest_q] | dest_mt_q;
                wr_st  = dest_st_q;
                if ({1'b0, dest_q} < ENTRIES_W) wr_en = 1'b1;
                else                            idx_err_d = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = cnt_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dest_en_q <= 1'b0;
            src_q     <= '0;
            dest_q    <= '0;
            src_mt_q  <= '0;
            dest_mt_q <= '0;
            src_st_q  <= '0;
            dest_st_q <= '0;
            done_q    <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dest_en_q <= dest_en_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            src_mt_q  <= src_mt_d;
            dest_mt_q <= dest_mt_d;
            src_st_q  <= src_st_d;
            dest_st_q <= dest_st_d;
            done_q    <= done_d;
            idx_err_q <= idx_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mt_q[i] <= '0;
                st_q[i] <= '0;
            end
        end else if (wr_en) begin
            mt_q[wr_idx] <= wr_mt;
            st_q[wr_idx] <= wr_st;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            mt_buffer[STEP_RANGE*i +: STEP_RANGE] = mt_q[i];
            st_buffer[2*i +: 2]                   = st_q[i];
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign idx_err = idx_err_q;

`ifdef REDUNDANCY_UPDATER_COUNT_EN
    logic [ITER_WIDTH:0] red_count_q, red_count_d;

    always_comb begin
        red_count_d = red_count_q;
        if (state_q == IDLE && clr_start)
            red_count_d = '0;
        else if (state_q == SRC_WR && src_st_q == 2'b10 && red_count_q != '1)
            red_count_d = red_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) red_count_q <= '0;
        else          red_count_q <= red_count_d;
    end

    assign red_count = red_count_q;
`endif
endmodule
